// File: rtl/sdram_write_if.sv
// Bundle between the controller FSM and the SDRAM write sequencer: request side plus SDRAM pin side.
interface sdram_write_if;
    logic        wr_en;
    logic [1:0]  ba;
    logic [12:0] row;
    logic [9:0]  col;
    logic [31:0] wdata;
    logic        wr_done;
    logic        busy;
    logic [3:0]  sdram_cmd;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;
    logic [31:0] sdram_dq_out;
    logic        sdram_dq_oe;
    logic [3:0]  sdram_dqm;

    modport master (
        output wr_en, ba, row, col, wdata,
        input  wr_done, busy, sdram_cmd, sdram_ba, sdram_addr,
               sdram_dq_out, sdram_dq_oe, sdram_dqm
    );

    modport slave (
        input  wr_en, ba, row, col, wdata,
        output wr_done, busy, sdram_cmd, sdram_ba, sdram_addr,
               sdram_dq_out, sdram_dq_oe, sdram_dqm
    );
endinterface

// File: rtl/sdram_write.sv
// Single-word SDRAM write sequencer: ACTIVE -> WRITE -> PRECHARGE with programmable spacing.
//
// state     | meaning
// ----------+----------------------------------------------------
// IDLE      | waiting for wr_en, latches bank/row/col/data on accept
// ACT       | issue ACTIVE with latched bank/row
// WAIT_RCD  | pad until WRITE is T_RCD cycles after ACTIVE
// WRITE     | issue WRITE, drive data with oe=1 and dqm=0
// WAIT_WR   | pad until PRECHARGE is T_WR cycles after WRITE
// PRE       | issue single-bank PRECHARGE
// WAIT_RP   | pad until wr_done is T_RP cycles after PRECHARGE
// DONE      | pulse wr_done, return to IDLE
module sdram_write #(
    parameter int T_RCD = 2,
    parameter int T_WR  = 2,
    parameter int T_RP  = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    sdram_write_if.slave bus
);
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_PRE   = 4'b0010;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ACT      = 3'd1;
    localparam logic [2:0] S_WAIT_RCD = 3'd2;
    localparam logic [2:0] S_WRITE    = 3'd3;
    localparam logic [2:0] S_WAIT_WR  = 3'd4;
    localparam logic [2:0] S_PRE      = 3'd5;
    localparam logic [2:0] S_WAIT_RP  = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    // Wait states last T_x-1 cycles; the counter is loaded with T_x-2 and exits on zero.
    localparam logic [3:0] LD_RCD = (T_RCD > 1) ? 4'(T_RCD - 2) : 4'd0;
    localparam logic [3:0] LD_WR  = (T_WR  > 1) ? 4'(T_WR  - 2) : 4'd0;
    localparam logic [3:0] LD_RP  = (T_RP  > 1) ? 4'(T_RP  - 2) : 4'd0;

    logic [2:0]  state;
    logic [3:0]  cnt;
    logic [1:0]  ba_q;
    logic [12:0] row_q;
    logic [9:0]  col_q;
    logic [31:0] wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            cnt              <= 4'd0;
            ba_q             <= 2'd0;
            row_q            <= 13'd0;
            col_q            <= 10'd0;
            wdata_q          <= 32'd0;
            bus.sdram_cmd    <= CMD_NOP;
            bus.sdram_ba     <= 2'd0;
            bus.sdram_addr   <= 13'd0;
            bus.sdram_dq_out <= 32'd0;
            bus.sdram_dq_oe  <= 1'b0;
            bus.sdram_dqm    <= 4'b1111;
            bus.wr_done      <= 1'b0;
            bus.busy         <= 1'b0;
        end else begin
            bus.sdram_cmd   <= CMD_NOP;
            bus.sdram_dq_oe <= 1'b0;
            bus.sdram_dqm   <= 4'b1111;
            bus.wr_done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    bus.busy <= 1'b0;
                    if (bus.wr_en) begin
                        ba_q    <= bus.ba;
                        row_q   <= bus.row;
                        col_q   <= bus.col;
                        wdata_q <= bus.wdata;
                        state   <= S_ACT;
                    end
                end
                S_ACT: begin
                    bus.sdram_cmd  <= CMD_ACT;
                    bus.sdram_ba   <= ba_q;
                    bus.sdram_addr <= row_q;
                    bus.busy       <= 1'b1;
                    cnt            <= LD_RCD;
                    state          <= (T_RCD > 1) ? S_WAIT_RCD : S_WRITE;
                end
                S_WAIT_RCD: begin
                    if (cnt == 4'd0) state <= S_WRITE;
                    else             cnt   <= cnt - 4'd1;
                end
                S_WRITE: begin
                    bus.sdram_cmd    <= CMD_WRITE;
                    bus.sdram_ba     <= ba_q;
                    bus.sdram_addr   <= {3'b000, col_q};
                    bus.sdram_dq_out <= wdata_q;
                    bus.sdram_dq_oe  <= 1'b1;
                    bus.sdram_dqm    <= 4'b0000;
                    cnt              <= LD_WR;
                    state            <= (T_WR > 1) ? S_WAIT_WR : S_PRE;
                end
                S_WAIT_WR: begin
                    if (cnt == 4'd0) state <= S_PRE;
                    else             cnt   <= cnt - 4'd1;
                end
                S_PRE: begin
                    bus.sdram_cmd  <= CMD_PRE;
                    bus.sdram_ba   <= ba_q;
                    bus.sdram_addr <= 13'd0;
                    cnt            <= LD_RP;
                    state          <= (T_RP > 1) ? S_WAIT_RP : S_DONE;
                end
                S_WAIT_RP: begin
                    if (cnt == 4'd0) state <= S_DONE;
                    else             cnt   <= cnt - 4'd1;
                end
                S_DONE: begin
                    bus.wr_done <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
